pool2d_stream: RTL

Parametrised streaming 2-D pooling layer for the CNN inference pipeline. It sits between a convolution stage and the next convolution or dense stage, in place of the fixed 2×2 max-pool stages. It generalises pooling to any channel count, square window size and data width, and adds an optional average mode. Features stream in and out one value per beat over valid/ready handshakes, in raster order with channels interleaved.

---
 rtl/pool2d_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pool2d_stream.sv
// pool2d_stream: streaming 2-D max/average pooling over raster, channel-interleaved features.
// Define POOL2D_AVG_EN to enable average mode (mode_i=1); otherwise max only.
module pool2d_stream #(
    parameter int DATA_WIDTH   = 16,
    parameter int IMAGE_HEIGHT = 28,
    parameter int IMAGE_WIDTH  = 28,
    parameter int CHANNELS     = 20,
    parameter int POOL         = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  out_last_o
);
`ifdef POOL2D_AVG_EN
    localparam int SH = 2 * $clog2(POOL);
    localparam int AW = DATA_WIDTH + SH;
`else
    localparam int AW = DATA_WIDTH;
`endif
    localparam int OW = IMAGE_WIDTH / POOL;
    localparam int OH = IMAGE_HEIGHT / POOL;
    localparam int N  = OW * CHANNELS;
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = $clog2(POOL);
    localparam int GW = OW > 1 ? $clog2(OW) : 1;
    localparam int HW = OH > 1 ? $clog2(OH) : 1;
    localparam int IW = N > 1 ? $clog2(N) : 1;

    if (POOL < 2 || IMAGE_WIDTH % POOL != 0 || IMAGE_HEIGHT % POOL != 0) begin : g_bad_cfg
        $error("pool2d_stream: POOL must be >=2 and divide both image dimensions");
    end
`ifdef POOL2D_AVG_EN
    if ((POOL & (POOL - 1)) != 0) begin : g_bad_pool
        $error("pool2d_stream: POOL must be a power of two for average mode");
    end
`endif

    // Position is tracked as (group, offset) pairs so no division by POOL is needed.
    logic [CW-1:0] ch_q, ch_d;
    logic [PW-1:0] pc_q, pc_d, pr_q, pr_d;
    logic [GW-1:0] gc_q, gc_d;
    logic [HW-1:0] gr_q, gr_d;
    logic signed [AW-1:0] acc_q [N];
    logic signed [AW-1:0] x, old, comb;
    logic [DATA_WIDTH-1:0] res, out_data_q;
    logic out_valid_q, out_last_q;
    logic fire, first, last, w_ch, w_pc, w_gc, w_pr;
    logic [IW-1:0] idx;
`ifdef POOL2D_AVG_EN
    logic frame_mode_q;
`else
    logic unused_mode;
    assign unused_mode = mode_i;
`endif

    assign in_ready_o  = !rst_i && (!out_valid_q || out_ready_i);
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;

    always_comb begin
        fire  = in_valid_i && in_ready_o;
        first = pr_q == '0 && pc_q == '0;
        last  = pr_q == PW'(POOL - 1) && pc_q == PW'(POOL - 1);
        w_ch  = ch_q == CW'(CHANNELS - 1);
        w_pc  = w_ch && pc_q == PW'(POOL - 1);
        w_gc  = w_pc && gc_q == GW'(OW - 1);
        w_pr  = w_gc && pr_q == PW'(POOL - 1);
        ch_d  = !fire ? ch_q : w_ch ? '0 : ch_q + 1'b1;
        pc_d  = !(fire && w_ch) ? pc_q : w_pc ? '0 : pc_q + 1'b1;
        gc_d  = !(fire && w_pc) ? gc_q : w_gc ? '0 : gc_q + 1'b1;
        pr_d  = !(fire && w_gc) ? pr_q : w_pr ? '0 : pr_q + 1'b1;
        gr_d  = !(fire && w_pr) ? gr_q : gr_q == HW'(OH - 1) ? '0 : gr_q + 1'b1;
        idx   = IW'(gc_q) * IW'(CHANNELS) + IW'(ch_q);
        x     = AW'($signed(in_data_i));
        old   = acc_q[idx];
`ifdef POOL2D_AVG_EN
        comb  = first ? x : frame_mode_q ? old + x : (x > old ? x : old);
        res   = frame_mode_q ? DATA_WIDTH'(comb >>> SH) : comb[DATA_WIDTH-1:0];
`else
        comb  = first ? x : (x > old ? x : old);
        res   = comb;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (fire)
            acc_q[idx] <= comb;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch_q        <= '0;
            pc_q        <= '0;
            gc_q        <= '0;
            pr_q        <= '0;
            gr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            ch_q <= ch_d;
            pc_q <= pc_d;
            gc_q <= gc_d;
            pr_q <= pr_d;
            gr_q <= gr_d;
            if (fire && last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res;
                out_last_q  <= w_ch && gc_q == GW'(OW - 1) && gr_q == HW'(OH - 1);
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef POOL2D_AVG_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)
            frame_mode_q <= 1'b0;
        else if (fire && ch_q == '0 && pc_q == '0 && gc_q == '0 && pr_q == '0 && gr_q == '0)
            frame_mode_q <= mode_i;
    end
`endif
endmodule
